// File: rtl/beam_strobe_gen_pkg.sv
// beam_strobe_gen_pkg: shared state encodings and pending-counter constants
package beam_strobe_gen_pkg;
  typedef enum logic [1:0] {DB_CLEAR, DB_ARM_BLK, DB_BLOCKED, DB_ARM_CLR} db_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_UP_LOW, ST_DN_LOW, ST_GAP} st_state_t;
  localparam int PEND_W = 2;
  localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p, input logic inc, input logic dec);
    return p + PEND_W'(inc) - PEND_W'(dec);
  endfunction
endpackage

// File: rtl/beam_debounce.sv
// beam_debounce: two-flop synchronizer plus level debounce FSM for one photo-beam
module beam_debounce
  import beam_strobe_gen_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic Resetn,
  input  logic i_beam,
  output logic o_blocked,
  output logic o_event
);
  logic [1:0] r_sync;
  logic [7:0] r_cnt, w_cnt_nxt;
  db_state_t r_state, w_state_nxt;
  logic w_beam, w_done;
  assign w_beam = r_sync[1];
  assign w_done = r_cnt == 8'(DB_CYCLES - 1);
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_sync  <= 2'b11;
      r_state <= DB_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_beam};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // the sample that enters an ARM state is the first of the run; DB_CYCLES more must agree
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      DB_CLEAR:   w_state_nxt = w_beam ? DB_CLEAR : DB_ARM_BLK;
      DB_ARM_BLK: begin
        w_state_nxt = w_beam ? DB_CLEAR : w_done ? DB_BLOCKED : DB_ARM_BLK;
        w_cnt_nxt   = (w_beam || w_done) ? '0 : r_cnt + 8'd1;
      end
      DB_BLOCKED: w_state_nxt = w_beam ? DB_ARM_CLR : DB_BLOCKED;
      DB_ARM_CLR: begin
        w_state_nxt = !w_beam ? DB_BLOCKED : w_done ? DB_CLEAR : DB_ARM_CLR;
        w_cnt_nxt   = (!w_beam || w_done) ? '0 : r_cnt + 8'd1;
      end
    endcase
  end
  always_comb begin
    o_blocked = r_state == DB_BLOCKED || r_state == DB_ARM_CLR;
    o_event   = r_state == DB_ARM_CLR && w_beam && w_done;
  end
endmodule

// File: rtl/beam_strobe_gen.sv
// beam_strobe_gen: debounced back/front beams queued into active-low up/down counter strobes
module beam_strobe_gen
  import beam_strobe_gen_pkg::*;
#(
  parameter int DB_CYCLES    = 16,
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic Resetn,
  input  logic back_beam_i,
  input  logic front_beam_i,
  output logic up_count,
  output logic down_count,
  output logic back_blocked,
  output logic front_blocked,
  output logic overrun
);
  st_state_t r_state, w_state_nxt;
  logic [3:0] r_pcnt, w_pcnt_nxt;
  logic [PEND_W-1:0] r_pend_up, r_pend_dn;
  logic r_up, r_dn, r_ovr, w_up_nxt, w_dn_nxt;
  logic w_back_ev, w_front_ev, w_last, w_dispatch, w_take_up, w_take_dn, w_ovf_up, w_ovf_dn;
  beam_debounce #(.DB_CYCLES(DB_CYCLES)) u_back (
    .clk(clk), .Resetn(Resetn), .i_beam(back_beam_i), .o_blocked(back_blocked), .o_event(w_back_ev)
  );
  beam_debounce #(.DB_CYCLES(DB_CYCLES)) u_front (
    .clk(clk), .Resetn(Resetn), .i_beam(front_beam_i), .o_blocked(front_blocked), .o_event(w_front_ev)
  );
  assign w_last = r_pcnt == 4'(PULSE_CYCLES - 1);
  // the last GAP cycle makes the IDLE decision itself so queued strobes are exactly PULSE_CYCLES apart
  assign w_dispatch = r_state == ST_IDLE || (r_state == ST_GAP && w_last);
  assign w_take_up  = w_dispatch && r_pend_up != '0;
  assign w_take_dn  = w_dispatch && r_pend_up == '0 && r_pend_dn != '0;
  assign w_ovf_up   = w_back_ev && !w_take_up && r_pend_up == PEND_MAX;
  assign w_ovf_dn   = w_front_ev && !w_take_dn && r_pend_dn == PEND_MAX;
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= ST_IDLE;
      r_pcnt    <= '0;
      r_pend_up <= '0;
      r_pend_dn <= '0;
      r_up      <= 1'b1;
      r_dn      <= 1'b1;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_pend_up <= pend_next(r_pend_up, w_back_ev && !w_ovf_up, w_take_up);
      r_pend_dn <= pend_next(r_pend_dn, w_front_ev && !w_ovf_dn, w_take_dn);
      r_up      <= w_up_nxt;
      r_dn      <= w_dn_nxt;
      r_ovr     <= r_ovr | w_ovf_up | w_ovf_dn;
    end
  end
  always_comb begin
    w_state_nxt = w_take_up ? ST_UP_LOW : w_take_dn ? ST_DN_LOW : ST_IDLE;
    w_pcnt_nxt  = '0;
    if (!w_dispatch) begin
      w_state_nxt = (r_state != ST_GAP && w_last) ? ST_GAP : r_state;
      w_pcnt_nxt  = w_last ? '0 : r_pcnt + 4'd1;
    end
  end
  always_comb begin
    w_up_nxt   = w_state_nxt != ST_UP_LOW;
    w_dn_nxt   = w_state_nxt != ST_DN_LOW;
    up_count   = r_up;
    down_count = r_dn;
    overrun    = r_ovr;
  end
endmodule

// File: tb/tb_beam_strobe_gen.sv
// tb_beam_strobe_gen: run-length beam model plus strobe schedule, checked every cycle, with directed scenarios
module tb_beam_strobe_gen;
  logic clk = 1'b0;
  logic Resetn = 1'b1;
  logic [1:0] bb = 2'b11;
  logic [1:0] fb = 2'b11;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // instance 0 uses the short-pulse timing, instance 1 long pulses so events can queue up
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DB = g == 0 ? 4 : 2;
    localparam int PC = g == 0 ? 2 : 15;
    logic up, dn, bblk, fblk, ovr;
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_lvl [2];
    int m_run [2];
    int m_pend [2];
    int m_kind, m_k;
    logic m_ovr;
    int up_falls = 0, dn_falls = 0, fblk_rises = 0, bblk_falls = 0;
    int up_fall_at = -1, up_rise_at = -1, dn_fall_at = -1, dn_rise_at = -1;
    logic p_up = 1'b1, p_dn = 1'b1, p_fblk = 1'b0, p_bblk = 1'b0;

    beam_strobe_gen #(.DB_CYCLES(DB), .PULSE_CYCLES(PC)) dut (
      .clk(clk), .Resetn(Resetn), .back_beam_i(bb[g]), .front_beam_i(fb[g]),
      .up_count(up), .down_count(dn), .back_blocked(bblk), .front_blocked(fblk), .overrun(ovr)
    );

    // accepted level flips after DB+1 consecutive disagreeing synced samples; strobes are slots of 2*PC cycles
    always @(posedge clk or negedge Resetn) begin
      int run, p, kind, k;
      logic ev, disp;
      if (!Resetn) begin
        for (int c = 0; c < 2; c++) begin
          m_s1[c] <= 1'b1; m_s2[c] <= 1'b1; m_lvl[c] <= 1'b1; m_run[c] <= 0; m_pend[c] <= 0;
        end
        m_kind <= 0; m_k <= 0; m_ovr <= 1'b0;
      end else begin
        disp = m_kind == 0 || m_k == 2 * PC - 1;
        kind = disp ? (m_pend[0] > 0 ? 1 : m_pend[1] > 0 ? 2 : 0) : m_kind;
        k = disp ? 0 : m_k + 1;
        for (int c = 0; c < 2; c++) begin
          ev = 1'b0;
          run = m_s2[c] != m_lvl[c] ? m_run[c] + 1 : 0;
          if (run == DB + 1) begin
            m_lvl[c] <= m_s2[c];
            ev = m_s2[c];
            run = 0;
          end
          m_run[c] <= run;
          p = m_pend[c] - ((disp && kind == c + 1) ? 1 : 0);
          if (ev) begin
            if (p == 3) m_ovr <= 1'b1;
            else p++;
          end
          m_pend[c] <= p;
          m_s2[c] <= m_s1[c];
          m_s1[c] <= c == 0 ? bb[g] : fb[g];
        end
        m_kind <= kind;
        m_k <= k;
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d up_count", g), up, (m_kind == 1 && m_k < PC) ? 0 : 1);
      chk($sformatf("u%0d down_count", g), dn, (m_kind == 2 && m_k < PC) ? 0 : 1);
      chk($sformatf("u%0d back_blocked", g), bblk, !m_lvl[0]);
      chk($sformatf("u%0d front_blocked", g), fblk, !m_lvl[1]);
      chk($sformatf("u%0d overrun", g), ovr, m_ovr);
      if (up != p_up) begin
        if (!up) begin up_falls++; up_fall_at = cyc; end
        else up_rise_at = cyc;
      end
      if (dn != p_dn) begin
        if (!dn) begin dn_falls++; dn_fall_at = cyc; end
        else dn_rise_at = cyc;
      end
      if (fblk && !p_fblk) fblk_rises++;
      if (!bblk && p_bblk) bblk_falls++;
      p_up <= up; p_dn <= dn; p_fblk <= fblk; p_bblk <= bblk;
    end
  end

  initial begin
    int r, f0, d0, b0;
    #1 Resetn = 1'b0;
    #1;
    chk("reset up_count", u[0].up, 1);
    chk("reset down_count", u[0].dn, 1);
    chk("reset back_blocked", u[0].bblk, 0);
    chk("reset front_blocked", u[0].fblk, 0);
    chk("reset overrun", u[0].ovr, 0);
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    repeat (3) @(negedge clk);

    f0 = u[0].up_falls; d0 = u[0].dn_falls;
    bb[0] = 1'b0;
    repeat (10) @(negedge clk);
    r = cyc; bb[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("single up pulses", u[0].up_falls - f0, 1);
    chk("single up start", u[0].up_fall_at, r + 1 + 7);
    chk("single up width", u[0].up_rise_at - u[0].up_fall_at, 2);
    chk("single down pulses", u[0].dn_falls - d0, 0);

    f0 = u[0].up_falls; d0 = u[0].dn_falls; b0 = u[0].fblk_rises;
    fb[0] = 1'b0;
    repeat (3) @(negedge clk);
    fb[0] = 1'b1;
    repeat (15) @(negedge clk);
    chk("short front blocked rises", u[0].fblk_rises - b0, 0);
    chk("short front down pulses", u[0].dn_falls - d0, 0);
    chk("short front up pulses", u[0].up_falls - f0, 0);

    bb[0] = 1'b0; fb[0] = 1'b0;
    repeat (10) @(negedge clk);
    r = cyc; bb[0] = 1'b1; fb[0] = 1'b1;
    repeat (25) @(negedge clk);
    chk("both up start", u[0].up_fall_at, r + 8);
    chk("both up end", u[0].up_rise_at, r + 10);
    chk("both down start", u[0].dn_fall_at, r + 12);
    chk("both down end", u[0].dn_rise_at, r + 14);

    f0 = u[0].up_falls; b0 = u[0].bblk_falls;
    bb[0] = 1'b0;
    repeat (10) @(negedge clk);
    bb[0] = 1'b1;
    @(negedge clk);
    bb[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch back_blocked", u[0].bblk, 1);
    chk("glitch blocked falls", u[0].bblk_falls - b0, 0);
    chk("glitch up pulses", u[0].up_falls - f0, 0);
    bb[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch release pulses", u[0].up_falls - f0, 1);

    f0 = u[1].up_falls; d0 = u[1].dn_falls;
    bb[1] = 1'b0; fb[1] = 1'b0;
    repeat (6) @(negedge clk);
    fb[1] = 1'b1;
    repeat (2) @(negedge clk);
    bb[1] = 1'b1;
    repeat (3) begin
      repeat (3) @(negedge clk);
      bb[1] = 1'b0;
      repeat (4) @(negedge clk);
      bb[1] = 1'b1;
    end
    repeat (140) @(negedge clk);
    chk("overflow up pulses", u[1].up_falls - f0, 3);
    chk("overflow down pulses", u[1].dn_falls - d0, 1);
    chk("overflow overrun", u[1].ovr, 1);
    repeat (20) @(negedge clk);
    chk("overrun sticky", u[1].ovr, 1);

    bb[0] = 1'b0;
    repeat (10) @(negedge clk);
    r = cyc; bb[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort first low cycle", u[0].up, 0);
    #1 Resetn = 1'b0; bb[0] = 1'b0;
    #1;
    chk("abort up_count", u[0].up, 1);
    chk("abort down_count", u[0].dn, 1);
    chk("abort back_blocked", u[0].bblk, 0);
    chk("abort front_blocked", u[0].fblk, 0);
    chk("abort overrun", u[1].ovr, 0);
    f0 = u[0].up_falls;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    @(negedge clk);
    chk("held beam after reset", u[0].bblk, 0);
    repeat (10) @(negedge clk);
    chk("held beam reblocked", u[0].bblk, 1);
    chk("no reissue after abort", u[0].up_falls - f0, 0);
    bb[0] = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
